mem_wb_stage: RTL and testbench



---
 rtl/mips_defs.sv | 50 +++++
 rtl/mem_wb_stage_dm_ram.sv | 34 +++
 rtl/mem_wb_stage.sv | 118 +++++++++++
 tb/tb_mem_wb_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode constants, instruction field positions,
// and the memory-operation decode that the pipeline stages reuse.
package mips_defs;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned OPC_W  = 6;

    localparam logic [OPC_W-1:0] OP_LW  = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW  = 6'h2b;
    localparam logic [OPC_W-1:0] OP_LB  = 6'h20;
    localparam logic [OPC_W-1:0] OP_LBU = 6'h24;
    localparam logic [OPC_W-1:0] OP_LH  = 6'h21;
    localparam logic [OPC_W-1:0] OP_LHU = 6'h25;
    localparam logic [OPC_W-1:0] OP_SB  = 6'h28;
    localparam logic [OPC_W-1:0] OP_SH  = 6'h29;

    typedef enum logic [3:0] {
        MOP_NONE,
        MOP_LW,
        MOP_SW,
        MOP_LB,
        MOP_LBU,
        MOP_LH,
        MOP_LHU,
        MOP_SB,
        MOP_SH
    } mem_op_e;

    // Map an opcode to a memory operation; subword ops only exist when enabled.
    function automatic mem_op_e decode_mem_op(input logic [OPC_W-1:0] opc,
                                              input logic             subword_en);
        mem_op_e op;
        op = MOP_NONE;
        case (opc)
            OP_LW:   op = MOP_LW;
            OP_SW:   op = MOP_SW;
            OP_LB:   op = subword_en ? MOP_LB  : MOP_NONE;
            OP_LBU:  op = subword_en ? MOP_LBU : MOP_NONE;
            OP_LH:   op = subword_en ? MOP_LH  : MOP_NONE;
            OP_LHU:  op = subword_en ? MOP_LHU : MOP_NONE;
            OP_SB:   op = subword_en ? MOP_SB  : MOP_NONE;
            OP_SH:   op = subword_en ? MOP_SH  : MOP_NONE;
            default: op = MOP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_wb_stage_dm_ram.sv
// Data memory: byte-enabled synchronous write, synchronous clear on reset,
// asynchronous read of the pre-edge contents.
module dm_ram #(
    parameter int unsigned DM_DEPTH = 1024,
    parameter int unsigned DM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       be,
    input  logic [DM_AW-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DM_DEPTH];

    // Reset clears every word and takes priority over a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data access and MEM/WB pipeline latch.
// Optional macro MEM_SUBWORD_EN enables lb/lbu/lh/lhu/sb/sh; without it
// only lw/sw access memory and subword opcodes behave as non-memory.
module mem_wb_stage
    import mips_defs::*;
#(
    parameter int unsigned DM_DEPTH = 1024,
    parameter int unsigned DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_In,
    input  logic [31:0] PC8_In,
    input  logic [31:0] AO_In,
    input  logic [31:0] RData2_In,
    input  logic        WriteEn_In,
    output logic [31:0] IR_Out,
    output logic [31:0] PC8_Out,
    output logic [31:0] AO_Out,
    output logic [31:0] DR_Out,
    output logic        WriteEn_Out
);

`ifdef MEM_SUBWORD_EN
    localparam logic SUBWORD_EN = 1'b1;
`else
    localparam logic SUBWORD_EN = 1'b0;
`endif

    mem_op_e          mem_op;
    logic [DM_AW-1:0] word_addr;
    logic [1:0]       byte_sel;
    logic             half_sel;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      load_data;
    logic             unused_ao_hi;

    assign mem_op    = decode_mem_op(IR_In[OPC_HI:OPC_LO], SUBWORD_EN);
    assign word_addr = AO_In[DM_AW+1:2];
    assign byte_sel  = AO_In[1:0];
    assign half_sel  = AO_In[1];

    // Upper address bits fall outside the array; addresses wrap.
    assign unused_ao_hi = ^AO_In[31:DM_AW+2];

    dm_ram #(
        .DM_DEPTH (DM_DEPTH),
        .DM_AW    (DM_AW)
    ) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .be    (be),
        .addr  (word_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Select the addressed byte and halfword of the read word.
    always_comb begin
        sel_byte = rdata[7:0];
        case (byte_sel)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = half_sel ? rdata[31:16] : rdata[15:0];
    end

    // Byte enables, lane-replicated store data and extended load data.
    always_comb begin
        be        = 4'b0000;
        wdata     = RData2_In;
        load_data = 32'h0;
        case (mem_op)
            MOP_SW:  be = 4'b1111;
            MOP_SB: begin
                be    = 4'b0001 << byte_sel;
                wdata = {4{RData2_In[7:0]}};
            end
            MOP_SH: begin
                be    = half_sel ? 4'b1100 : 4'b0011;
                wdata = {2{RData2_In[15:0]}};
            end
            MOP_LW:  load_data = rdata;
            MOP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            MOP_LBU: load_data = {24'h0, sel_byte};
            MOP_LH:  load_data = {{16{sel_half[15]}}, sel_half};
            MOP_LHU: load_data = {16'h0, sel_half};
            default: begin
                be        = 4'b0000;
                load_data = 32'h0;
            end
        endcase
    end

    // MEM/WB pipeline latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            IR_Out      <= 32'h0;
            PC8_Out     <= 32'h0;
            AO_Out      <= 32'h0;
            DR_Out      <= 32'h0;
            WriteEn_Out <= 1'b0;
        end else begin
            IR_Out      <= IR_In;
            PC8_Out     <= PC8_In;
            AO_Out      <= AO_In;
            DR_Out      <= load_data;
            WriteEn_Out <= WriteEn_In;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected MEM/WB contents
// from a byte-level memory model, monitor pops and compares after each edge.
module tb_mem_wb_stage;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic [31:0] IR_In, PC8_In, AO_In, RData2_In;
    logic        WriteEn_In;
    logic [31:0] IR_Out, PC8_Out, AO_Out, DR_Out;
    logic        WriteEn_Out;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] dr;
        logic        we;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mdl [DEPTH*4];
    int          errors = 0;
    int          checks = 0;
    bit          drive_done = 0;

    mem_wb_stage #(.DM_DEPTH(DEPTH), .DM_AW(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .IR_In       (IR_In),
        .PC8_In      (PC8_In),
        .AO_In       (AO_In),
        .RData2_In   (RData2_In),
        .WriteEn_In  (WriteEn_In),
        .IR_Out      (IR_Out),
        .PC8_Out     (PC8_Out),
        .AO_Out      (AO_Out),
        .DR_Out      (DR_Out),
        .WriteEn_Out (WriteEn_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endfunction

    // Byte-addressed reference memory, little-endian within a word.
    function automatic int unsigned baddr(input logic [31:0] a);
        return int'(a % (DEPTH*4));
    endfunction

    function automatic logic [31:0] rd_bytes(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[baddr(a) + i]) << (8*i));
        return v;
    endfunction

    function automatic void wr_bytes(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) mdl[baddr(a) + i] = 8'((d >> (8*i)) & 32'hff);
    endfunction

    function automatic exp_t model(input logic rst, input logic [31:0] ir, input logic [31:0] pc8,
                                   input logic [31:0] ao, input logic [31:0] rd, input logic we);
        exp_t e;
        logic [31:0] v;
        logic [5:0]  op;
        e = '0;
        if (rst) begin
            for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h0;
            return e;
        end
        e.ir = ir; e.pc8 = pc8; e.ao = ao; e.we = we; e.dr = 32'h0;
        op = ir[31:26];
        case (op)
            6'h23: e.dr = rd_bytes(ao & ~32'h3, 4);
            6'h2b: wr_bytes(ao & ~32'h3, rd, 4);
`ifdef MEM_SUBWORD_EN
            6'h20: begin v = rd_bytes(ao, 1); e.dr = (v >= 32'h80) ? (v | 32'hFFFFFF00) : v; end
            6'h24: e.dr = rd_bytes(ao, 1);
            6'h21: begin v = rd_bytes(ao & ~32'h1, 2); e.dr = (v >= 32'h8000) ? (v | 32'hFFFF0000) : v; end
            6'h25: e.dr = rd_bytes(ao & ~32'h1, 2);
            6'h28: wr_bytes(ao, rd, 1);
            6'h29: wr_bytes(ao & ~32'h1, rd, 2);
`endif
            default: e.dr = 32'h0;
        endcase
        return e;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ir, input logic [31:0] pc8,
                        input logic [31:0] ao, input logic [31:0] rd, input logic we);
        @(negedge clk);
        reset = rst; IR_In = ir; PC8_In = pc8; AO_In = ao; RData2_In = rd; WriteEn_In = we;
        sbq.push_back(model(rst, ir, pc8, ao, rd, we));
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] rest);
        return {op, rest};
    endfunction

    // Monitor: the stage presents a new MEM/WB word after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("ir",  IR_Out,  e.ir);
                check("pc8", PC8_Out, e.pc8);
                check("ao",  AO_Out,  e.ao);
                check("dr",  DR_Out,  e.dr);
                check("we",  32'(WriteEn_Out), 32'(e.we));
            end
        end
    end

    initial begin
        logic [5:0]  ops [10];
        logic [5:0]  op;
        logic [31:0] ao;
        ops = '{6'h23, 6'h2b, 6'h20, 6'h24, 6'h21, 6'h25, 6'h28, 6'h29, 6'h00, 6'h0f};
        reset = 1'b1; IR_In = 32'h0; PC8_In = 32'h0; AO_In = 32'h0; RData2_In = 32'h0; WriteEn_In = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, mk(6'h23, 26'h0), 32'h108, 32'h0000_0abc, 0, 1);
        step(0, mk(6'h2b, 26'h1), 32'h10c, 32'h10, 32'hDEADBEEF, 0);
        step(0, mk(6'h23, 26'h2), 32'h110, 32'h10, 0, 1);
        step(0, mk(6'h2b, 26'h3), 32'h114, 32'h4, 32'h11111111, 0);
        step(0, mk(6'h2b, 26'h4), 32'h118, 32'h4 + DEPTH*4, 32'h22222222, 0);
        step(0, mk(6'h23, 26'h5), 32'h11c, 32'h4, 0, 1);
        step(0, mk(6'h2b, 26'h6), 32'h120, 32'h20, 32'h12345680, 0);
        step(0, mk(6'h28, 26'h7), 32'h124, 32'h21, 32'h000000FF, 0);
        step(0, mk(6'h23, 26'h8), 32'h128, 32'h20, 0, 1);
        step(0, mk(6'h20, 26'h9), 32'h12c, 32'h20, 0, 1);
        step(0, mk(6'h24, 26'ha), 32'h130, 32'h20, 0, 1);
        step(0, mk(6'h21, 26'hb), 32'h134, 32'h22, 0, 1);
        step(0, mk(6'h29, 26'hc), 32'h138, 32'h23, 32'h0000ABCD, 0);
        step(0, mk(6'h25, 26'hd), 32'h13c, 32'h22, 0, 1);
        step(1, mk(6'h2b, 26'he), 32'h140, 32'h8, 32'hCAFEF00D, 1);
        step(0, mk(6'h23, 26'hf), 32'h144, 32'h8, 0, 1);
        step(0, 32'h00221820, 32'h148, 32'h55, 32'h77777777, 1);
        step(0, mk(6'h23, 26'h10), 32'h14c, 32'h54, 0, 1);

        for (int n = 0; n < 600; n++) begin
            op = ops[$urandom_range(0, 9)];
            ao = 32'($urandom_range(0, 3)) * (DEPTH*4) + 32'($urandom_range(0, 63));
            step(($urandom_range(0, 79) == 0), mk(op, 26'($urandom)), $urandom, ao, $urandom,
                 1'($urandom));
        end

        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
